display_scan_ctrl: RTL

Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display. It holds a 16-bit hex value and cycles one digit at a time through an internal hex-to-segment decoder. It drives the active-low anodes with a guard interval between digits to suppress ghosting. New values are double-buffered and committed only at a frame boundary, so a scan frame never mixes old and new digits.

---
 rtl/display_scan_ctrl_pkg.sv | 29 ++
 rtl/display_scan_ctrl_hex_to_sseg.sv | 32 +++
 rtl/display_scan_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: blank/off patterns,
// digit count and the active-low abcdefg glyph table.
package display_scan_ctrl_pkg;

    typedef logic [6:0] sseg_t;

    localparam sseg_t      SSEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam int         NUM_DIGITS = 4;

    // Glyphs are written a..g from left to right, 0 = segment lit.
    localparam sseg_t GLYPH_0 = 7'b0000001;
    localparam sseg_t GLYPH_1 = 7'b1001111;
    localparam sseg_t GLYPH_2 = 7'b0010010;
    localparam sseg_t GLYPH_3 = 7'b0000110;
    localparam sseg_t GLYPH_4 = 7'b1001100;
    localparam sseg_t GLYPH_5 = 7'b0100100;
    localparam sseg_t GLYPH_6 = 7'b0100000;
    localparam sseg_t GLYPH_7 = 7'b0001111;
    localparam sseg_t GLYPH_8 = 7'b0000000;
    localparam sseg_t GLYPH_9 = 7'b0000100;
    localparam sseg_t GLYPH_A = 7'b0001000;
    localparam sseg_t GLYPH_B = 7'b1100000;
    localparam sseg_t GLYPH_C = 7'b0110001;
    localparam sseg_t GLYPH_D = 7'b1000010;
    localparam sseg_t GLYPH_E = 7'b0110000;
    localparam sseg_t GLYPH_F = 7'b0111000;

endpackage

// File: rtl/display_scan_ctrl_hex_to_sseg.sv
// Purely combinational hex nibble to active-low seven-segment decoder.
module hex_to_sseg
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [0:6] sseg
);

    always_comb begin
        sseg = SSEG_BLANK;
        unique case (hex)
            4'h0: sseg = GLYPH_0;
            4'h1: sseg = GLYPH_1;
            4'h2: sseg = GLYPH_2;
            4'h3: sseg = GLYPH_3;
            4'h4: sseg = GLYPH_4;
            4'h5: sseg = GLYPH_5;
            4'h6: sseg = GLYPH_6;
            4'h7: sseg = GLYPH_7;
            4'h8: sseg = GLYPH_8;
            4'h9: sseg = GLYPH_9;
            4'hA: sseg = GLYPH_A;
            4'hB: sseg = GLYPH_B;
            4'hC: sseg = GLYPH_C;
            4'hD: sseg = GLYPH_D;
            4'hE: sseg = GLYPH_E;
            4'hF: sseg = GLYPH_F;
            default: sseg = SSEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed seven-segment scan controller with frame-aligned,
// double-buffered value updates. Optional LEADING_ZERO_BLANK_EN blanks leading zeros.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int GUARD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  en_mask,
    output logic        ready,
    output logic [0:6]  SSeg,
    output logic [3:0]  an,
    output logic        frame
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       dig_reg;
    logic [15:0]      shown_reg;
    logic [15:0]      pending_reg;
    logic             ready_reg;
    logic             frame_reg;
    logic [3:0]       an_reg;
    logic [0:6]       sseg_reg;

    logic             slot_end;
    logic             boundary;
    logic [3:0]       nibble [NUM_DIGITS];
    logic [3:0]       cur_hex;
    logic [0:6]       dec_sseg;
    logic [3:0]       visible;
    logic             lit;
    logic [3:0]       an_next;
    logic [0:6]       sseg_next;

    assign slot_end = (cnt_reg == CNT_W'(DIV - 1));
    assign boundary = slot_end && (dig_reg == 2'd3);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
            assign nibble[gi] = shown_reg[4*gi +: 4];
        end
    endgenerate

    assign cur_hex = nibble[dig_reg];

    hex_to_sseg u_hex_to_sseg (
        .hex  (cur_hex),
        .sseg (dec_sseg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k is significant when it or any digit above it is nonzero.
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_visible
            if (gi == 0) begin : g_lsd
                assign visible[gi] = 1'b1;
            end else begin : g_upper
                assign visible[gi] = |shown_reg[4*NUM_DIGITS-1 : 4*gi];
            end
        end
    endgenerate
`else
    assign visible = 4'b1111;
`endif

    // Outputs are computed from the current slot and registered, so they
    // trail cnt/dig by one cycle; the guard window hides that lag.
    assign lit       = (cnt_reg >= CNT_W'(GUARD)) && en_mask[dig_reg] && visible[dig_reg];
    assign an_next   = lit ? ~(4'b0001 << dig_reg) : AN_OFF;
    assign sseg_next = lit ? dec_sseg : SSEG_BLANK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            dig_reg     <= '0;
            shown_reg   <= '0;
            pending_reg <= '0;
            ready_reg   <= 1'b1;
            frame_reg   <= 1'b0;
            an_reg      <= AN_OFF;
            sseg_reg    <= SSEG_BLANK;
        end else begin
            cnt_reg   <= slot_end ? '0 : cnt_reg + 1'b1;
            if (slot_end) begin
                dig_reg <= dig_reg + 2'd1;
            end
            an_reg    <= an_next;
            sseg_reg  <= sseg_next;
            frame_reg <= boundary;
            // A commit wins over a coincident load, which is then dropped.
            if (boundary && !ready_reg) begin
                shown_reg <= pending_reg;
                ready_reg <= 1'b1;
            end else if (load && ready_reg) begin
                pending_reg <= value;
                ready_reg   <= 1'b0;
            end
        end
    end

    assign ready = ready_reg;
    assign frame = frame_reg;
    assign an    = an_reg;
    assign SSeg  = sseg_reg;

endmodule
